// File: rtl/hog_pack_pkg.sv
// rtl/hog_pack_pkg.sv - shared types, defaults and helpers for the HOG feature packer
package hog_pack_pkg;

    localparam int FEA_I_DEF = 4;
    localparam int FEA_F_DEF = 8;

    // Feature width from integer and fractional bit counts
    function automatic int fea_w(input int fea_i, input int fea_f);
        return fea_i + fea_f;
    endfunction

    typedef logic [FEA_I_DEF+FEA_F_DEF-1:0] fea_t;

    typedef enum logic {ST_EMPTY, ST_FILL} pack_st_e;

endpackage

// File: rtl/hog_fea_packer_if.sv
// rtl/hog_fea_packer_if.sv - feature input and packed-word stream bundle (o_last with HOG_FEA_PACK_LAST_EN)
interface hog_fea_packer_if #(
    parameter int FEA_W = 12,
    parameter int LANES = 4,
    parameter int LVL_W = 4
);
    logic [FEA_W-1:0]       i_fea;
    logic                   i_valid;
    logic                   i_flush;
    logic [FEA_W*LANES-1:0] o_data;
    logic                   o_valid;
    logic                   i_ready;
    logic [LVL_W-1:0]       o_level;
    logic                   o_ovf;
`ifdef HOG_FEA_PACK_LAST_EN
    logic                   o_last;
`endif

    // Packer side
    modport master (
`ifdef HOG_FEA_PACK_LAST_EN
        output o_last,
`endif
        input  i_fea, i_valid, i_flush, i_ready,
        output o_data, o_valid, o_level, o_ovf
    );

    // Feature source / word consumer side
    modport slave (
`ifdef HOG_FEA_PACK_LAST_EN
        input  o_last,
`endif
        output i_fea, i_valid, i_flush, i_ready,
        input  o_data, o_valid, o_level, o_ovf
    );

endinterface

// File: rtl/hog_sync_fifo.sv
// rtl/hog_sync_fifo.sv - first-word-fall-through synchronous FIFO with level counter
module hog_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and level; storage cleared so the head is never X
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/hog_fea_packer.sv
// rtl/hog_fea_packer.sv - packs single-lane HOG features into LANES-wide FIFO-buffered words (option HOG_FEA_PACK_LAST_EN)
module hog_fea_packer
    import hog_pack_pkg::*;
#(
    parameter int  FEA_I = FEA_I_DEF,
    parameter int  FEA_F = FEA_F_DEF,
    parameter int  LANES = 4,
    parameter int  DEPTH = 8,
    localparam int FEA_W = fea_w(FEA_I, FEA_F),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    hog_fea_packer_if.master  bus
);
    localparam int CNT_W  = $clog2(LANES);
    localparam int WORD_W = FEA_W * LANES;
`ifdef HOG_FEA_PACK_LAST_EN
    localparam int FIFO_W = WORD_W + 1;
`else
    localparam int FIFO_W = WORD_W;
`endif

    pack_st_e          state_q, state_d;
    logic [CNT_W-1:0]  lane_cnt_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] word_d;
    logic              complete;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              ovf_q;

    // Word as it stands after this cycle's feature, plus push decision
    always_comb begin
        word_d = acc_q;
        if (bus.i_valid) word_d[lane_cnt_q*FEA_W +: FEA_W] = bus.i_fea;
        complete = bus.i_valid && (lane_cnt_q == CNT_W'(LANES - 1));
        push     = complete || (bus.i_flush && (state_q == ST_FILL || bus.i_valid));
    end

    // Accumulator next state: any push returns to EMPTY
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (bus.i_valid && !push) state_d = ST_FILL;
            ST_FILL:  if (push)                 state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Accumulator state, lane counter and partial word; unfilled lanes stay zero
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            lane_cnt_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                lane_cnt_q <= '0;
                acc_q      <= '0;
            end else if (bus.i_valid) begin
                lane_cnt_q <= lane_cnt_q + 1'b1;
                acc_q      <= word_d;
            end
        end
    end

    // Sticky overflow: a word arrived with the FIFO full and no pop to make room
    always_ff @(posedge clk) begin
        if (rst)                               ovf_q <= 1'b0;
        else if (push && fifo_full && !pop)    ovf_q <= 1'b1;
    end

    assign pop = !fifo_empty && bus.i_ready;

`ifdef HOG_FEA_PACK_LAST_EN
    assign fifo_din   = {bus.i_flush, word_d};
    assign bus.o_last = fifo_dout[WORD_W];
`else
    assign fifo_din   = word_d;
`endif

    hog_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .level (bus.o_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.o_data  = fifo_dout[WORD_W-1:0];
    assign bus.o_valid = !fifo_empty;
    assign bus.o_ovf   = ovf_q;

endmodule

// File: doc/hog_fea_packer.md
Name: hog_fea_packer

Overview:
- Parametrised successor to the HOG feature output stage.
- Collects the single-lane HOG feature strobe (one FEA_W feature per valid cycle) into LANES-wide words.
- Buffers the words in a DEPTH-entry first-word-fall-through FIFO.
- Presents the words on a valid/ready stream toward the bus/DMA side. Sits between the HOG normaliser output and the system interconnect.

Parameters:
- FEA_I, 4, integer bits of a HOG feature
- FEA_F, 8, fractional bits of a HOG feature
- FEA_W, FEA_I+FEA_F (localparam), feature width
- LANES, 4, features per output word (power of two, ≥2)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- LVL_W, $clog2(DEPTH+1) (localparam), level counter width

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- i_fea  in  FEA_W  feature from HOG core
- i_valid  in  1  i_fea valid this cycle (no backpressure upstream)
- i_flush  in  1  pulse: close current partial word (end of frame)
- o_data  out  FEA_W*LANES  packed word, lane 0 in LSBs
- o_valid  out  1  FIFO head valid
- i_ready  in  1  downstream accepts head
- o_level  out  LVL_W  words currently in FIFO
- o_ovf  out  1  sticky: a completed word was dropped

Behaviour:
- Reset: rst=1 at a posedge clears lane counter, accumulator, FIFO pointers and o_ovf. Afterwards o_valid=0, o_level=0, o_ovf=0, o_data=0.
- rst has priority over every other input. Reset mid-word discards the partial word; reset mid-stream discards FIFO contents.
- Accumulator FSM has two states:
  - EMPTY (lane_cnt=0).
  - FILL (0<lane_cnt<LANES).
  - Each i_valid writes i_fea into lane lane_cnt.
  - EMPTY→FILL on i_valid.
  - FILL→EMPTY when lane LANES-1 is written (word complete) or on flush.
- Push: a completed word is pushed into the FIFO on the same edge that captures its last feature. It appears on o_data/o_valid the next cycle (1-cycle latency from the last i_valid).
- Flush:
  - In FILL, i_flush pushes the partial word with unfilled lanes zero.
  - i_valid and i_flush together: the feature is written first, then the word is pushed.
  - In EMPTY with i_valid=0, i_flush is a no-op.
  - A flush arriving exactly on word completion pushes one word only.
- Pop: o_valid && i_ready at a posedge removes the head. o_data is stable while o_valid=1 and i_ready=0.
- Full: a push when o_level=DEPTH and no pop that cycle drops the word and sets o_ovf. o_ovf stays set until rst.
- Push and pop in the same cycle while full: the pop frees a slot, the push is accepted, and o_level is unchanged.
- Push and pop in the same cycle while empty: not possible (FWFT, no bypass). The word becomes visible next cycle.
- o_level: +1 on push, -1 on pop, unchanged on both or neither. Saturates between 0 and DEPTH by construction.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty come from o_level.
- o_data is X-free: the storage array is reset to 0.

Optional Feature:
- Macro HOG_FEA_PACK_LAST_EN.
- When defined:
  - Adds output port o_last (1 bit), stored as an extra FIFO bit.
  - o_last=1 on any word pushed because of i_flush, including a full word completed in the same cycle as i_flush.
  - Reset value 0.
- When undefined: no o_last port, no extra storage bit, and behaviour is otherwise identical.

Decomposition:
- Package hog_pack_pkg holds:
  - FEA_I/FEA_F defaults and the FEA_W function.
  - typedef fea_t.
  - typedef enum {ST_EMPTY, ST_FILL} pack_st_e.
- One sub-module, hog_sync_fifo, parametrised by width and depth: FWFT, synchronous rst, push/pop/level/full/empty. The packer instantiates it with width FEA_W*LANES (+1 with the macro).

Test Plan (FEA_W=12, LANES=4, DEPTH=4):
- Features 0x001,0x002,0x003,0x004 on consecutive cycles, i_ready=1 → one cycle after the 4th, o_valid=1, o_data=0x004003002001, o_level=1. Popped next edge, o_level returns to 0.
- Features 0xAAA,0xBBB then i_flush alone → o_data=0x000000BBBAAA. With the macro, o_last=1. A second i_flush in EMPTY produces nothing.
- i_ready=0, 20 features streamed → o_level reaches 4 after 16 features, the 5th word is dropped, o_ovf=1. Draining yields words 1–4 intact, and o_ovf stays 1.
- FIFO full with i_ready=1 on the cycle the 5th word completes → word accepted, o_level stays 4, o_ovf=0.
- Three features then rst=1 for one cycle, then four new features 0x010..0x013 → only word 0x013012011010 emerges; all outputs are 0 during reset.
- i_valid with 0x7FF together with i_flush in FILL (lane_cnt=3) → single word with lane 3=0x7FF. With the macro, o_last=1. Nothing else is pushed.
